// File: rtl/fpnew_noncomp_arbiter.sv
// fpnew_noncomp_arbiter
// Round-robin front end that shares one non-computational FP unit (sign
// injection, min/max, compare) between NumReq issue ports. Each issued
// operation is tagged with its requester index, the number of operations
// in flight is capped at MaxOutstanding, and results are steered back to
// the owning requester by their returned tag.
//
// Optional feature: define FPNEW_NONCOMP_ARB_LOCK_EN to add req_lock_i,
// which lets a requester keep the grant across back-to-back handshakes.
// Without the macro the port is absent and arbitration is pure round-robin.
//
// The arbiter is purely combinational on the request and response paths;
// the only state is the rotation pointer, the in-flight counter, the sticky
// tag error flag and (with locking) the lock owner.

module fpnew_noncomp_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned ReqWidth       = 72,
  parameter int unsigned RspWidth       = 38,
  parameter int unsigned MaxOutstanding = 4,
  // Derived; do not override.
  parameter int unsigned IdWidth        = $clog2(NumReq)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,

  // Requester side, issue direction
  input  logic [NumReq-1:0]                req_valid_i,
  output logic [NumReq-1:0]                req_ready_o,
  input  logic [NumReq-1:0][ReqWidth-1:0]  req_data_i,
`ifdef FPNEW_NONCOMP_ARB_LOCK_EN
  input  logic [NumReq-1:0]                req_lock_i,
`endif

  // Unit input handshake
  output logic                             unit_valid_o,
  input  logic                             unit_ready_i,
  output logic [ReqWidth-1:0]              unit_data_o,
  output logic [IdWidth-1:0]               unit_tag_o,
  output logic                             unit_flush_o,

  // Unit output handshake
  input  logic                             unit_out_valid_i,
  output logic                             unit_out_ready_o,
  input  logic [RspWidth-1:0]              unit_out_data_i,
  input  logic [IdWidth-1:0]               unit_out_tag_i,

  // Requester side, response direction
  output logic [NumReq-1:0]                rsp_valid_o,
  input  logic [NumReq-1:0]                rsp_ready_i,
  output logic [RspWidth-1:0]              rsp_data_o,

  // Control and status
  input  logic                             flush_i,
  output logic                             busy_o,
  output logic                             tag_err_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  // Constants sized to the vectors they are compared against.
  localparam logic [CntWidth-1:0] CntMax    = CntWidth'(MaxOutstanding);
  localparam logic [IdWidth-1:0]  LastIdx   = IdWidth'(NumReq - 1);
  localparam logic [IdWidth:0]    NumReqExt = (IdWidth + 1)'(NumReq);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [IdWidth-1:0]  ptr_q, ptr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                tag_err_q, tag_err_d;

  // ---------------------------------------------------------------------
  // Combinational nets
  // ---------------------------------------------------------------------
  logic               gnt_found;
  logic [IdWidth-1:0] gnt_idx;
  logic [IdWidth:0]   cand_ext;
  logic [IdWidth-1:0] cand;
  logic               issue;
  logic               tag_ok;
  logic               sel_rsp_ready;
  logic               retire;
  logic               cnt_zero;

`ifdef FPNEW_NONCOMP_ARB_LOCK_EN
  logic               locked_q, locked_d;
  logic [IdWidth-1:0] lock_id_q, lock_id_d;
  logic               lock_hold;

  // The lock only steers the grant while its owner still has a request up;
  // once the owner drops valid, normal rotation takes over immediately.
  assign lock_hold = locked_q && req_valid_i[lock_id_q];
`endif

  // Rotating priority search starting at ptr_q, or the lock owner if held.
  always_comb begin
    // NOTE: every variable written here gets a default before any branch,
    // so no path leaves a value unassigned and no latch is inferred.
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_ext  = '0;
    cand      = '0;
`ifdef FPNEW_NONCOMP_ARB_LOCK_EN
    if (lock_hold) begin
      gnt_found = 1'b1;
      gnt_idx   = lock_id_q;
    end else
`endif
    begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        // ptr_q < NumReq and i < NumReq, so one conditional subtract wraps.
        cand_ext = {1'b0, ptr_q} + (IdWidth + 1)'(i);
        if (cand_ext >= NumReqExt) begin
          cand_ext = cand_ext - NumReqExt;
        end
        cand = cand_ext[IdWidth-1:0];
        if (!gnt_found && req_valid_i[cand]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end

  // Issue side: valid is independent of unit_ready_i, and the cap is checked
  // against the registered count only, so a same-cycle retire never bypasses.
  always_comb begin
    unit_valid_o = !rst_i && gnt_found && (cnt_q != CntMax) && !flush_i;
    issue        = unit_valid_o && unit_ready_i;
    req_ready_o  = '0;
    if (issue) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  assign unit_data_o  = req_data_i[gnt_idx];
  assign unit_tag_o   = gnt_idx;
  assign unit_flush_o = !rst_i && flush_i;

  // Response side: steer valid to the tagged requester and take its ready;
  // out-of-range tags are swallowed so the unit never stalls on them.
  always_comb begin
    tag_ok        = ({1'b0, unit_out_tag_i} < NumReqExt);
    sel_rsp_ready = 1'b0;
    rsp_valid_o   = '0;
    for (int unsigned r = 0; r < NumReq; r++) begin
      if (unit_out_tag_i == IdWidth'(r)) begin
        rsp_valid_o[r] = unit_out_valid_i && !rst_i;
        sel_rsp_ready  = rsp_ready_i[r];
      end
    end
    unit_out_ready_o = !rst_i && (tag_ok ? sel_rsp_ready : 1'b1);
    retire           = unit_out_valid_i && unit_out_ready_o;
  end

  assign rsp_data_o = unit_out_data_i;
  assign cnt_zero   = (cnt_q == '0);
  assign busy_o     = !rst_i && (!cnt_zero || (|req_valid_i));
  assign tag_err_o  = !rst_i && tag_err_q;

  // Next-state for pointer, in-flight counter and sticky error flag.
  always_comb begin
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    tag_err_d = tag_err_q;

    // Rotate past the winner; a locking handshake keeps the pointer put.
`ifdef FPNEW_NONCOMP_ARB_LOCK_EN
    if (issue && !req_lock_i[gnt_idx]) begin
`else
    if (issue) begin
`endif
      ptr_d = (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
    end

    // A retire at zero would underflow: ignore it and report it instead.
    if (flush_i) begin
      cnt_d = '0;
    end else if (issue && !(retire && !cnt_zero)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!issue && retire && !cnt_zero) begin
      cnt_d = cnt_q - 1'b1;
    end

    if ((unit_out_valid_i && !tag_ok) || (retire && cnt_zero)) begin
      tag_err_d = 1'b1;
    end
  end

  // Core state register with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed above, independent of statement order.
    if (rst_i) begin
      ptr_q     <= '0;
      cnt_q     <= '0;
      tag_err_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      tag_err_q <= tag_err_d;
    end
  end

`ifdef FPNEW_NONCOMP_ARB_LOCK_EN
  // Lock bookkeeping: set on a locking handshake, released by a non-locking
  // handshake, by the owner dropping its request, or by a flush.
  always_comb begin
    locked_d  = locked_q;
    lock_id_d = lock_id_q;
    if (locked_q && !req_valid_i[lock_id_q]) begin
      locked_d = 1'b0;
    end
    if (issue) begin
      if (req_lock_i[gnt_idx]) begin
        locked_d  = 1'b1;
        lock_id_d = gnt_idx;
      end else begin
        locked_d  = 1'b0;
      end
    end
    if (flush_i) begin
      locked_d = 1'b0;
    end
  end

  // Lock state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      locked_q  <= 1'b0;
      lock_id_q <= '0;
    end else begin
      locked_q  <= locked_d;
      lock_id_q <= lock_id_d;
    end
  end
`endif

endmodule

// File: doc/fpnew_noncomp_arbiter.md
# fpnew_noncomp_arbiter

Round-robin arbiter that shares one non-computational FP unit (sign injection, min/max, compare) among `NumReq` requesters. Sits between issue ports and the unit's input handshake. Tags each issued operation with the requester index, caps in-flight operations, and routes results back by tag.

## Interface
Parameters:
- `NumReq`, 4: number of requesters, 2..16.
- `ReqWidth`, 72: opaque request payload width: operands, op, op_mod, rnd_mode, boxing.
- `RspWidth`, 38: opaque response payload width: result, status, extension bit.
- `MaxOutstanding`, 4: maximum in-flight operations, 1..15.
- `IdWidth`, `$clog2(NumReq)`: derived tag width. Do not override.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  NumReq  request valid, one bit per requester.
- `req_ready_o`  out  NumReq  request accepted.
- `req_data_i`  in  NumReq×ReqWidth  request payloads.
- `req_lock_i`  in  NumReq  keep grant after this handshake. Present only with `FPNEW_NONCOMP_ARB_LOCK_EN`.
- `unit_valid_o`  out  1  issue valid to the unit.
- `unit_ready_i`  in  1  unit input ready.
- `unit_data_o`  out  ReqWidth  granted payload.
- `unit_tag_o`  out  IdWidth  granted requester index.
- `unit_flush_o`  out  1  flush to the unit.
- `unit_out_valid_i`  in  1  unit result valid.
- `unit_out_ready_o`  out  1  result accepted.
- `unit_out_data_i`  in  RspWidth  unit result.
- `unit_out_tag_i`  in  IdWidth  returned tag.
- `rsp_valid_o`  out  NumReq  result valid, per requester.
- `rsp_ready_i`  in  NumReq  requester ready for result.
- `rsp_data_o`  out  RspWidth  result payload, broadcast to all requesters.
- `flush_i`  in  1  kill all in-flight work.
- `busy_o`  out  1  count nonzero or any request pending.
- `tag_err_o`  out  1  sticky flag: a result returned with tag ≥ NumReq.

## Operation
- State:
  - `ptr`: round-robin pointer, IdWidth bits.
  - `cnt`: in-flight count, `$clog2(MaxOutstanding+1)` bits.
  - `locked`: 1 bit.
  - `lock_id`: IdWidth bits.
  - `tag_err`: 1 bit.
- Grant is combinational. Pick the first `k` with `req_valid_i[k]`, searching `ptr, ptr+1, …` mod `NumReq`.
- `unit_valid_o` = any grant && `cnt != MaxOutstanding` && !`flush_i`.
- `unit_data_o`/`unit_tag_o` = payload/index of `k`.
- `req_ready_o[k]` = `unit_valid_o && unit_ready_i`. All other bits are 0.
- Issue handshake (`unit_valid_o && unit_ready_i`): `ptr <= (k+1) mod NumReq`.
- No same-cycle bypass at the cap: `cnt == MaxOutstanding` blocks issue even if a retire happens that cycle.
- Response routing, for `t = unit_out_tag_i`:
  - `rsp_valid_o[t]` = `unit_out_valid_i`.
  - `unit_out_ready_o` = `rsp_ready_i[t]`.
  - `rsp_data_o` = `unit_out_data_i`.
  - If `t ≥ NumReq`: result is dropped, `unit_out_ready_o` = 1, `tag_err` is set. `tag_err` clears only on reset.
- `cnt` update:
  - +1 on issue handshake.
  - −1 on retire handshake (`unit_out_valid_i && unit_out_ready_o`), including dropped results.
  - Both in one cycle: unchanged.
  - Never wraps. A retire with `cnt == 0` is ignored and sets `tag_err`.
- Flush:
  - `unit_flush_o` = `flush_i` (combinational).
  - Next cycle: `cnt` = 0 and `locked` = 0. `ptr` is held.
  - Results presented during the `flush_i` cycle are still routed, but do not decrement `cnt`.
- `tag_err_o` = `tag_err`. `busy_o` = (`cnt != 0`) || |`req_valid_i`.

## Timing
- Reset (synchronous, `rst_i` high at the clock edge) clears `ptr`, `cnt`, `locked`, `lock_id`, `tag_err`.
- Outputs while in reset:
  - `req_ready_o` = 0, `unit_valid_o` = 0, `rsp_valid_o` = 0, `tag_err_o` = 0.
  - `unit_out_ready_o` = 0, `unit_flush_o` = 0, `busy_o` = 0.
- Reset asserted mid-operation discards all state. The integrating design must flush the unit on the same cycle.
- Latency:
  - Request→unit: 0 cycles (combinational).
  - Unit→requester: 0 cycles.
  - Adds no register stage to the unit's pipeline.
- Valid/ready rules:
  - `unit_valid_o` never depends on `unit_ready_i`.
  - A held request keeps its grant only if no higher-rotation requester is pending; grant may move while `unit_ready_i` is low.

## Configuration
- `FPNEW_NONCOMP_ARB_LOCK_EN` defined:
  - `req_lock_i` exists.
  - An issue handshake from `k` with `req_lock_i[k]` = 1 sets `locked`, `lock_id` = k, and leaves `ptr` unchanged.
  - While `locked`, only `lock_id` may be granted; others see ready = 0.
  - `locked` clears on a handshake with lock = 0, when `req_valid_i[lock_id]` drops, on flush, or on reset.
- Undefined: `req_lock_i` is absent and arbitration is pure round-robin.

## Test plan
- Reset, then all 4 requesters valid with `unit_ready_i` = 1 → grants 0,1,2,3,0 on consecutive cycles; `unit_tag_o` matches.
- `MaxOutstanding` = 2, no results returned → after 2 issues `unit_valid_o` = 0 and `cnt` = 2; one retire → issue resumes the next cycle.
- Result with tag 2 and `rsp_ready_i` = 4'b0000 → `rsp_valid_o` = 4'b0100 and `unit_out_ready_o` = 0; raising `rsp_ready_i[2]` → retire, `cnt` decrements.
- Issue and retire in the same cycle at `cnt` = 1 → `cnt` stays 1; `flush_i` pulse with `cnt` = 3 → `unit_flush_o` = 1, `cnt` = 0 next cycle, `ptr` unchanged.
- `NumReq` = 3, result tag 3 → result dropped, `unit_out_ready_o` = 1, `tag_err_o` = 1 until reset.
- With `FPNEW_NONCOMP_ARB_LOCK_EN`: requester 1 issues 3 ops with lock = 1 while 0, 2, 3 are valid → three consecutive grants to 1, then round-robin resumes at 2.
